// File: rtl/misao_result_monitor.sv
// misao_result_monitor: NUM_CH independent watchpoint channels on the MISA-O
// read bus. Each armed channel waits for a read of its address, checks the
// returned byte, waits `delay` cycles, then checks the core's ACC/carry and
// reports done/pass plus a first-fail latch with a reason code.
module misao_result_monitor #(
  parameter  int unsigned NUM_CH  = 4,
  parameter  int unsigned ADDR_W  = 15,
  parameter  int unsigned MEM_W   = 8,
  parameter  int unsigned DATA_W  = 16,
  parameter  int unsigned DELAY_W = 4,
  parameter  int unsigned TMO_W   = 8,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [TMO_W-1:0]  cfg_timeout,
  input  logic [MEM_W-1:0]  cfg_rdata,
  input  logic [MEM_W-1:0]  cfg_rmask,
  input  logic [DATA_W-1:0] cfg_exp,
  input  logic [DATA_W-1:0] cfg_emask,
  input  logic              cfg_carry,
  input  logic              cfg_cchk,
  input  logic              clr,
  input  logic              mem_enable_read,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [MEM_W-1:0]  mem_data_in,
  input  logic [DATA_W-1:0] test_data,
  input  logic              test_carry,
  output logic [NUM_CH-1:0] ch_done,
  output logic [NUM_CH-1:0] ch_pass,
  output logic              all_done,
  output logic              fail_valid,
  output logic [CH_W-1:0]   fail_ch,
  output logic [1:0]        fail_reason
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e              state_q  [NUM_CH];
  state_e              state_d  [NUM_CH];
  logic [ADDR_W-1:0]   addr_q   [NUM_CH];
  logic [ADDR_W-1:0]   addr_d   [NUM_CH];
  logic [DELAY_W-1:0]  delay_q  [NUM_CH];
  logic [DELAY_W-1:0]  delay_d  [NUM_CH];
  logic [TMO_W-1:0]    tmo_q    [NUM_CH];
  logic [TMO_W-1:0]    tmo_d    [NUM_CH];
  logic [MEM_W-1:0]    rdata_q  [NUM_CH];
  logic [MEM_W-1:0]    rdata_d  [NUM_CH];
  logic [MEM_W-1:0]    rmask_q  [NUM_CH];
  logic [MEM_W-1:0]    rmask_d  [NUM_CH];
  logic [DATA_W-1:0]   exp_q    [NUM_CH];
  logic [DATA_W-1:0]   exp_d    [NUM_CH];
  logic [DATA_W-1:0]   emask_q  [NUM_CH];
  logic [DATA_W-1:0]   emask_d  [NUM_CH];
  logic                carry_q  [NUM_CH];
  logic                carry_d  [NUM_CH];
  logic                cchk_q   [NUM_CH];
  logic                cchk_d   [NUM_CH];
  logic [TMO_W-1:0]    tcnt_q   [NUM_CH];
  logic [TMO_W-1:0]    tcnt_d   [NUM_CH];
  logic [DELAY_W-1:0]  cnt_q    [NUM_CH];
  logic [DELAY_W-1:0]  cnt_d    [NUM_CH];
  logic                rderr_q  [NUM_CH];
  logic                rderr_d  [NUM_CH];
  logic [1:0]          reason_q [NUM_CH];
  logic [1:0]          reason_d [NUM_CH];

  logic [NUM_CH-1:0]   done_q, done_d;
  logic [NUM_CH-1:0]   pass_q, pass_d;
  logic                fail_valid_q, fail_valid_d;
  logic [CH_W-1:0]     fail_ch_q, fail_ch_d;
  logic [1:0]          fail_reason_q, fail_reason_d;

  logic [NUM_CH-1:0]   hit;
  logic [NUM_CH-1:0]   rd_bad;
  logic [NUM_CH-1:0]   res_bad;
  logic [NUM_CH-1:0]   fin;
  logic [1:0]          fin_reason [NUM_CH];

  logic                new_fail;
  logic [CH_W-1:0]     new_ch;
  logic [1:0]          new_reason;

  // Per-channel bus hit and compare terms against the stored expectations.
  always_comb begin
    hit     = '0;
    rd_bad  = '0;
    res_bad = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      hit[i]     = mem_enable_read && (mem_addr == addr_q[i]);
      rd_bad[i]  = |((mem_data_in ^ rdata_q[i]) & rmask_q[i]);
      res_bad[i] = (|((test_data ^ exp_q[i]) & emask_q[i])) |
                   (cchk_q[i] & (test_carry ^ carry_q[i]));
    end
  end

  // Channel next-state: arming overrides everything, including a hit in the same cycle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    delay_d    = delay_q;
    tmo_d      = tmo_q;
    rdata_d    = rdata_q;
    rmask_d    = rmask_q;
    exp_d      = exp_q;
    emask_d    = emask_q;
    carry_d    = carry_q;
    cchk_d     = cchk_q;
    tcnt_d     = tcnt_q;
    cnt_d      = cnt_q;
    rderr_d    = rderr_q;
    reason_d   = reason_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fin        = '0;
    fin_reason = '{default: '0};
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg_we && (32'(cfg_ch) == i)) begin
        addr_d[i]   = cfg_addr;
        delay_d[i]  = cfg_delay;
        tmo_d[i]    = cfg_timeout;
        rdata_d[i]  = cfg_rdata;
        rmask_d[i]  = cfg_rmask;
        exp_d[i]    = cfg_exp;
        emask_d[i]  = cfg_emask;
        carry_d[i]  = cfg_carry;
        cchk_d[i]   = cfg_cchk;
        tcnt_d[i]   = '0;
        cnt_d[i]    = '0;
        rderr_d[i]  = 1'b0;
        reason_d[i] = 2'd0;
        done_d[i]   = 1'b0;
        pass_d[i]   = 1'b0;
        state_d[i]  = ST_ARMED;
      end else begin
        case (state_q[i])
          ST_ARMED: begin
            if (hit[i]) begin
              rderr_d[i] = rd_bad[i];
              if (delay_q[i] == '0) begin
                fin[i]        = 1'b1;
                fin_reason[i] = rd_bad[i] ? 2'd1 : (res_bad[i] ? 2'd2 : 2'd0);
              end else begin
                cnt_d[i]   = delay_q[i];
                state_d[i] = ST_COUNT;
              end
            end else if (tmo_q[i] != '0) begin
              if (TMO_W'(tcnt_q[i] + 1'b1) == tmo_q[i]) begin
                fin[i]        = 1'b1;
                fin_reason[i] = 2'd3;
              end else begin
                tcnt_d[i] = TMO_W'(tcnt_q[i] + 1'b1);
              end
            end
          end
          ST_COUNT: begin
            if (cnt_q[i] == DELAY_W'(1)) begin
              fin[i]        = 1'b1;
              fin_reason[i] = rderr_q[i] ? 2'd1 : (res_bad[i] ? 2'd2 : 2'd0);
            end else begin
              cnt_d[i] = DELAY_W'(cnt_q[i] - 1'b1);
            end
          end
          default: ;
        endcase
        if (fin[i]) begin
          state_d[i]  = ST_DONE;
          done_d[i]   = 1'b1;
          pass_d[i]   = (fin_reason[i] == 2'd0);
          reason_d[i] = fin_reason[i];
        end
      end
    end
  end

  // First-fail latch: lowest failing index this cycle; a new failure beats clr.
  always_comb begin
    new_fail   = 1'b0;
    new_ch     = '0;
    new_reason = 2'd0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (fin[i-1] && (fin_reason[i-1] != 2'd0)) begin
        new_fail   = 1'b1;
        new_ch     = CH_W'(i - 1);
        new_reason = fin_reason[i-1];
      end
    end
    fail_valid_d  = fail_valid_q;
    fail_ch_d     = fail_ch_q;
    fail_reason_d = fail_reason_q;
    if (new_fail && (!fail_valid_q || clr)) begin
      fail_valid_d  = 1'b1;
      fail_ch_d     = new_ch;
      fail_reason_d = new_reason;
    end else if (clr) begin
      fail_valid_d  = 1'b0;
      fail_ch_d     = '0;
      fail_reason_d = 2'd0;
    end
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= '{default: ST_IDLE};
      addr_q        <= '{default: '0};
      delay_q       <= '{default: '0};
      tmo_q         <= '{default: '0};
      rdata_q       <= '{default: '0};
      rmask_q       <= '{default: '0};
      exp_q         <= '{default: '0};
      emask_q       <= '{default: '0};
      carry_q       <= '{default: '0};
      cchk_q        <= '{default: '0};
      tcnt_q        <= '{default: '0};
      cnt_q         <= '{default: '0};
      rderr_q       <= '{default: '0};
      reason_q      <= '{default: '0};
      done_q        <= '0;
      pass_q        <= '0;
      fail_valid_q  <= 1'b0;
      fail_ch_q     <= '0;
      fail_reason_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      delay_q       <= delay_d;
      tmo_q         <= tmo_d;
      rdata_q       <= rdata_d;
      rmask_q       <= rmask_d;
      exp_q         <= exp_d;
      emask_q       <= emask_d;
      carry_q       <= carry_d;
      cchk_q        <= cchk_d;
      tcnt_q        <= tcnt_d;
      cnt_q         <= cnt_d;
      rderr_q       <= rderr_d;
      reason_q      <= reason_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_valid_q  <= fail_valid_d;
      fail_ch_q     <= fail_ch_d;
      fail_reason_q <= fail_reason_d;
    end
  end

  // all_done is a direct decode of the channel states.
  always_comb begin
    all_done = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if ((state_q[i] == ST_ARMED) || (state_q[i] == ST_COUNT)) all_done = 1'b0;
    end
  end

  assign ch_done     = done_q;
  assign ch_pass     = pass_q;
  assign fail_valid  = fail_valid_q;
  assign fail_ch     = fail_ch_q;
  assign fail_reason = fail_reason_q;

endmodule

// File: tb/tb_misao_result_monitor.sv
// Self-checking bench for misao_result_monitor: table vectors, hand-written
// corner sequences and random traffic, all cross-checked against a cycle-count
// based reference model.
module tb_misao_result_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [14:0] cfg_addr;
  logic [3:0]  cfg_delay;
  logic [7:0]  cfg_timeout;
  logic [7:0]  cfg_rdata;
  logic [7:0]  cfg_rmask;
  logic [15:0] cfg_exp;
  logic [15:0] cfg_emask;
  logic        cfg_carry;
  logic        cfg_cchk;
  logic        clr;
  logic        mem_enable_read;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data_in;
  logic [15:0] test_data;
  logic        test_carry;
  logic [3:0]  ch_done;
  logic [3:0]  ch_pass;
  logic        all_done;
  logic        fail_valid;
  logic [1:0]  fail_ch;
  logic [1:0]  fail_reason;

  misao_result_monitor #(
    .NUM_CH (4), .ADDR_W (15), .MEM_W (8), .DATA_W (16), .DELAY_W (4), .TMO_W (8)
  ) dut (
    .clk (clk), .rst (rst), .cfg_we (cfg_we), .cfg_ch (cfg_ch), .cfg_addr (cfg_addr),
    .cfg_delay (cfg_delay), .cfg_timeout (cfg_timeout), .cfg_rdata (cfg_rdata),
    .cfg_rmask (cfg_rmask), .cfg_exp (cfg_exp), .cfg_emask (cfg_emask),
    .cfg_carry (cfg_carry), .cfg_cchk (cfg_cchk), .clr (clr),
    .mem_enable_read (mem_enable_read), .mem_addr (mem_addr), .mem_data_in (mem_data_in),
    .test_data (test_data), .test_carry (test_carry), .ch_done (ch_done),
    .ch_pass (ch_pass), .all_done (all_done), .fail_valid (fail_valid),
    .fail_ch (fail_ch), .fail_reason (fail_reason)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc    = 0;

  // Reference model: a channel is "waiting" from arming until its result is
  // known; the finishing edge is derived from arm/hit edge numbers.
  logic [14:0] c_addr  [4];
  int          c_delay [4];
  int          c_tmo   [4];
  logic [7:0]  c_rdata [4];
  logic [7:0]  c_rmask [4];
  logic [15:0] c_exp   [4];
  logic [15:0] c_emask [4];
  logic        c_carry [4];
  logic        c_cchk  [4];
  bit          m_wait  [4];
  bit          m_hit   [4];
  bit          m_rderr [4];
  int          m_arm_n [4];
  int          m_smp_n [4];
  logic [3:0]  m_done, m_pass;
  logic        m_fv;
  logic [1:0]  m_fch, m_frs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] result_reason(input int i);
    bit bad;
    bad = (((test_data ^ c_exp[i]) & c_emask[i]) != 16'h0) ||
          (c_cchk[i] && (test_carry != c_carry[i]));
    if (m_rderr[i]) return 2'd1;
    if (bad) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      c_addr[i] = '0; c_delay[i] = 0; c_tmo[i] = 0; c_rdata[i] = '0; c_rmask[i] = '0;
      c_exp[i] = '0; c_emask[i] = '0; c_carry[i] = 0; c_cchk[i] = 0;
      m_wait[i] = 0; m_hit[i] = 0; m_rderr[i] = 0; m_arm_n[i] = 0; m_smp_n[i] = 0;
    end
    m_done = '0; m_pass = '0; m_fv = 0; m_fch = '0; m_frs = '0;
  endtask

  task automatic model_step();
    bit         found;
    logic [1:0] fch, frs;
    found = 0; fch = '0; frs = '0;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      bit         fin;
      logic [1:0] r;
      fin = 0; r = '0;
      if (cfg_we && (int'(cfg_ch) == i)) begin
        c_addr[i] = cfg_addr; c_delay[i] = int'(cfg_delay); c_tmo[i] = int'(cfg_timeout);
        c_rdata[i] = cfg_rdata; c_rmask[i] = cfg_rmask; c_exp[i] = cfg_exp;
        c_emask[i] = cfg_emask; c_carry[i] = cfg_carry; c_cchk[i] = cfg_cchk;
        m_wait[i] = 1; m_hit[i] = 0; m_rderr[i] = 0; m_arm_n[i] = n_cyc;
        m_done[i] = 0; m_pass[i] = 0;
      end else if (m_wait[i] && !m_hit[i]) begin
        if (mem_enable_read && (mem_addr == c_addr[i])) begin
          m_rderr[i] = ((mem_data_in ^ c_rdata[i]) & c_rmask[i]) != 8'h0;
          if (c_delay[i] == 0) begin
            fin = 1; r = result_reason(i);
          end else begin
            m_hit[i] = 1; m_smp_n[i] = n_cyc + c_delay[i];
          end
        end else if ((c_tmo[i] != 0) && (n_cyc - m_arm_n[i] == c_tmo[i])) begin
          fin = 1; r = 2'd3;
        end
      end else if (m_wait[i] && m_hit[i] && (n_cyc == m_smp_n[i])) begin
        fin = 1; r = result_reason(i);
      end
      if (fin) begin
        m_wait[i] = 0; m_done[i] = 1; m_pass[i] = (r == 2'd0);
        if ((r != 2'd0) && !found) begin
          found = 1; fch = 2'(i); frs = r;
        end
      end
    end
    if (found && (!m_fv || clr)) begin
      m_fv = 1; m_fch = fch; m_frs = frs;
    end else if (clr) begin
      m_fv = 0; m_fch = '0; m_frs = '0;
    end
  endtask

  function automatic logic [13:0] model_vec();
    logic ad;
    ad = 1;
    for (int i = 0; i < 4; i++) if (m_wait[i]) ad = 0;
    return {m_done, m_pass, ad, m_fv, m_fch, m_frs};
  endfunction

  // One clock: advance model with the inputs seen at this edge, compare after it,
  // then drop the one-shot strobes.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model", 32'({ch_done, ch_pass, all_done, fail_valid, fail_ch, fail_reason}),
        32'(model_vec()));
    n_cyc++;
    cfg_we = 0; clr = 0; mem_enable_read = 0;
  endtask

  task automatic set_cfg(input int ch, input logic [14:0] a, input int d, input int t,
                         input logic [7:0] rd, input logic [7:0] rm,
                         input logic [15:0] e, input logic [15:0] em,
                         input logic cy, input logic cc);
    cfg_we = 1; cfg_ch = 2'(ch); cfg_addr = a; cfg_delay = 4'(d); cfg_timeout = 8'(t);
    cfg_rdata = rd; cfg_rmask = rm; cfg_exp = e; cfg_emask = em;
    cfg_carry = cy; cfg_cchk = cc;
  endtask

  task automatic read(input logic [14:0] a, input logic [7:0] d);
    mem_enable_read = 1; mem_addr = a; mem_data_in = d;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".ch_done"}, 32'(ch_done), 32'h0);
    chk({tag, ".ch_pass"}, 32'(ch_pass), 32'h0);
    chk({tag, ".all_done"}, 32'(all_done), 32'h1);
    chk({tag, ".fail_valid"}, 32'(fail_valid), 32'h0);
    chk({tag, ".fail_ch"}, 32'(fail_ch), 32'h0);
    chk({tag, ".fail_reason"}, 32'(fail_reason), 32'h0);
  endtask

  typedef struct {
    logic [14:0] addr;  int delay;
    logic [7:0]  rdata; logic [7:0]  rmask; logic [7:0] bus;
    logic [15:0] exp;   logic [15:0] emask; logic carry; logic cchk;
    logic [15:0] tdata; logic tcarry;
    logic [1:0]  reason;
  } vec_t;

  vec_t vt [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; cfg_we = 0; cfg_ch = 0; cfg_addr = 0; cfg_delay = 0; cfg_timeout = 0;
    cfg_rdata = 0; cfg_rmask = 0; cfg_exp = 0; cfg_emask = 0; cfg_carry = 0; cfg_cchk = 0;
    clr = 0; mem_enable_read = 0; mem_addr = 0; mem_data_in = 0; test_data = 0; test_carry = 0;
    model_reset();

    vt[0] = '{15'd3, 0, 8'hA5, 8'hFF, 8'hA5, 16'h1234, 16'hFFFF, 1'b1, 1'b1, 16'h1234, 1'b1, 2'd0};
    vt[1] = '{15'd4, 2, 8'hA5, 8'h0F, 8'h35, 16'h00F0, 16'h00F0, 1'b1, 1'b0, 16'h12F7, 1'b0, 2'd0};
    vt[2] = '{15'd5, 1, 8'h00, 8'h00, 8'h77, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 2'd2};
    vt[3] = '{15'd6, 3, 8'h00, 8'h00, 8'h00, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h7FFF, 1'b0, 2'd2};
    vt[4] = '{15'd7, 1, 8'h80, 8'h80, 8'h00, 16'h0042, 16'hFFFF, 1'b0, 1'b0, 16'h0042, 1'b0, 2'd1};
    vt[5] = '{15'd8, 0, 8'hFF, 8'h01, 8'hFE, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd1};
    vt[6] = '{15'd9, 15, 8'h3C, 8'hFF, 8'h3C, 16'hBEEF, 16'hFFFF, 1'b0, 1'b1, 16'hBEEF, 1'b0, 2'd0};

    // Reset state
    tick(); tick();
    rst = 0;
    check_reset_values("reset");

    // Table vectors on channel 0; latch cleared at each arm
    for (int k = 0; k < 7; k++) begin
      set_cfg(0, vt[k].addr, vt[k].delay, 0, vt[k].rdata, vt[k].rmask,
              vt[k].exp, vt[k].emask, vt[k].carry, vt[k].cchk);
      clr = 1;
      tick();
      test_data = vt[k].tdata; test_carry = vt[k].tcarry;
      read(vt[k].addr, vt[k].bus);
      tick();
      for (int j = 0; j < vt[k].delay; j++) begin
        chk("tbl.early_done", 32'(ch_done[0]), 32'h0);
        tick();
      end
      chk("tbl.done", 32'(ch_done[0]), 32'h1);
      chk("tbl.pass", 32'(ch_pass[0]), 32'(vt[k].reason == 2'd0));
      chk("tbl.fail_valid", 32'(fail_valid), 32'(vt[k].reason != 2'd0));
      chk("tbl.fail_reason", 32'(fail_reason), 32'(vt[k].reason));
    end

    // LDI-style pass on ch0
    set_cfg(0, 15'd1, 1, 0, 8'h50, 8'hF0, 16'h0005, 16'h000F, 1'b0, 1'b0);
    clr = 1;
    tick();
    read(15'd1, 8'h5A); test_data = 16'hAB00;
    tick();
    chk("ldi.not_yet", 32'(ch_done[0]), 32'h0);
    test_data = 16'hAB05;
    tick();
    chk("ldi.done", 32'(ch_done[0]), 32'h1);
    chk("ldi.pass", 32'(ch_pass[0]), 32'h1);
    chk("ldi.fail_valid", 32'(fail_valid), 32'h0);

    // Two channels, different addresses, both pass
    set_cfg(1, 15'd5, 1, 0, 8'h00, 8'h00, 16'h00AB, 16'h00FF, 1'b0, 1'b0); tick();
    set_cfg(2, 15'd10, 1, 0, 8'h00, 8'h00, 16'h1234, 16'hFFFF, 1'b0, 1'b0); tick();
    chk("lk.all_done_busy", 32'(all_done), 32'h0);
    read(15'd5, 8'h11); tick();
    test_data = 16'h00AB; tick();
    read(15'd10, 8'h22); tick();
    test_data = 16'h1234; tick();
    chk("lk.done", 32'(ch_done[2:1]), 32'h3);
    chk("lk.pass", 32'(ch_pass[2:1]), 32'h3);
    chk("lk.all_done", 32'(all_done), 32'h1);

    // Simultaneous failure of ch1 and ch3: lowest index latched
    set_cfg(1, 15'd20, 2, 0, 8'h00, 8'h00, 16'h1111, 16'hFFFF, 1'b0, 1'b0); tick();
    set_cfg(3, 15'd20, 2, 0, 8'h00, 8'h00, 16'h1111, 16'hFFFF, 1'b0, 1'b0); tick();
    read(15'd20, 8'h00); test_data = 16'h2222; tick();
    tick(); tick();
    chk("dual.fail_valid", 32'(fail_valid), 32'h1);
    chk("dual.fail_ch", 32'(fail_ch), 32'h1);
    chk("dual.fail_reason", 32'(fail_reason), 32'h2);
    chk("dual.done", 32'(ch_done & 4'b1010), 32'hA);
    set_cfg(0, 15'd21, 0, 0, 8'hFF, 8'hFF, 16'h0000, 16'h0000, 1'b0, 1'b0); tick();
    read(15'd21, 8'h00); tick();
    chk("hold.ch0_done", 32'(ch_done[0]), 32'h1);
    chk("hold.fail_ch", 32'(fail_ch), 32'h1);
    chk("hold.fail_reason", 32'(fail_reason), 32'h2);
    clr = 1; tick();
    chk("clr.fail_valid", 32'(fail_valid), 32'h0);

    // Timeout exactly 20 cycles after arming
    set_cfg(0, 15'h7FFF, 1, 20, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0); tick();
    for (int j = 0; j < 19; j++) tick();
    chk("tmo.not_yet", 32'(ch_done[0]), 32'h0);
    tick();
    chk("tmo.done", 32'(ch_done[0]), 32'h1);
    chk("tmo.fail_reason", 32'(fail_reason), 32'h3);
    clr = 1; tick();
    set_cfg(0, 15'h7FFF, 1, 0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0); tick();
    for (int j = 0; j < 300; j++) tick();
    chk("tmo0.all_done", 32'(all_done), 32'h0);
    chk("tmo0.done", 32'(ch_done[0]), 32'h0);

    // delay=0 read mismatch beats result mismatch
    set_cfg(0, 15'd2, 0, 0, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0); tick();
    read(15'd2, 8'h00); test_data = 16'h0000; tick();
    chk("rd.done", 32'(ch_done[0]), 32'h1);
    chk("rd.pass", 32'(ch_pass[0]), 32'h0);
    chk("rd.fail_reason", 32'(fail_reason), 32'h1);
    clr = 1; tick();
    // re-arm in the same cycle as a hit: hit ignored
    set_cfg(0, 15'd2, 0, 0, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    read(15'd2, 8'h00); tick();
    tick(); tick();
    chk("rearm.done", 32'(ch_done[0]), 32'h0);
    chk("rearm.all_done", 32'(all_done), 32'h0);
    chk("rearm.fail_valid", 32'(fail_valid), 32'h0);

    // Failure in the same cycle as clr replaces the held latch
    set_cfg(3, 15'd31, 0, 0, 8'hFF, 8'hFF, 16'h0000, 16'h0000, 1'b0, 1'b0); tick();
    read(15'd31, 8'h00); tick();
    chk("clrrace.first", 32'(fail_ch), 32'h3);
    set_cfg(1, 15'd30, 0, 0, 8'hFF, 8'hFF, 16'h0000, 16'h0000, 1'b0, 1'b0); tick();
    read(15'd30, 8'h00); clr = 1; tick();
    chk("clrrace.valid", 32'(fail_valid), 32'h1);
    chk("clrrace.ch", 32'(fail_ch), 32'h1);
    chk("clrrace.reason", 32'(fail_reason), 32'h1);

    // Reset while ch2 is counting
    set_cfg(2, 15'd40, 3, 0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0); tick();
    read(15'd40, 8'h00); tick();
    tick();
    rst = 1; tick(); rst = 0;
    check_reset_values("rstcnt");
    for (int j = 0; j < 5; j++) tick();
    chk("rstcnt.ch2", 32'(ch_done[2]), 32'h0);

    // Random traffic against the model
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 7) == 0)
        set_cfg(int'($urandom_range(0, 3)), 15'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12)),
                8'($urandom), 8'($urandom_range(0, 1) == 0 ? 0 : $urandom),
                16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) read(15'($urandom_range(0, 7)), 8'($urandom));
      test_data  = 16'($urandom_range(0, 3));
      test_carry = 1'($urandom);
      clr        = ($urandom_range(0, 15) == 0);
      rst        = ($urandom_range(0, 499) == 0);
      tick();
      rst = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/misao_result_monitor.md
Name: misao_result_monitor

Overview:
- Synthesizable, parametrised watchpoint/scoreboard that generalises the global testbench validator into reusable RTL.
- It has NUM_CH independent channels. Each channel is armed with a fetch address, a delay, expected read data and an expected masked ACC/carry result.
- Each channel watches the MISA-O memory read bus, then samples the core's test_data/test_carry and reports pass/fail with a reason code.
- It sits beside misao in simulation benches and in FPGA self-test wrappers. It replaces $fatal-based checks with status outputs.

Parameters:
- NUM_CH, 4: number of independent check channels (1..16).
- ADDR_W, 15: memory address width.
- MEM_W, 8: memory data width.
- DATA_W, 16: test_data width.
- DELAY_W, 4: width of the post-hit delay counter.
- TMO_W, 8: width of the arm-to-hit timeout counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_we  in  1  arm or re-arm the channel selected by cfg_ch.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel index; values >= NUM_CH are ignored.
- cfg_addr  in  ADDR_W  watched read address.
- cfg_delay  in  DELAY_W  cycles from address hit to result sample.
- cfg_timeout  in  TMO_W  maximum cycles in ARMED; 0 disables the timeout.
- cfg_rdata  in  MEM_W  expected mem_data_in at the hit.
- cfg_rmask  in  MEM_W  bits of the read data that are compared.
- cfg_exp  in  DATA_W  expected test_data.
- cfg_emask  in  DATA_W  bits of test_data that are compared.
- cfg_carry  in  1  expected test_carry.
- cfg_cchk  in  1  enables the carry compare.
- clr  in  1  clears the first-fail latch only.
- mem_enable_read  in  1  core read strobe.
- mem_addr  in  ADDR_W  core address.
- mem_data_in  in  MEM_W  memory data returned to the core.
- test_data  in  DATA_W  core ACC observation.
- test_carry  in  1  core carry observation.
- ch_done  out  NUM_CH  channel reached DONE.
- ch_pass  out  NUM_CH  channel finished with no error.
- all_done  out  1  no channel is in ARMED or COUNT.
- fail_valid  out  1  at least one failure since reset or clr.
- fail_ch  out  $clog2(NUM_CH)  index of the first failing channel.
- fail_reason  out  2  reason code: 0 none, 1 read mismatch, 2 result mismatch, 3 timeout.

Behaviour:
- Reset:
  - All channels go to IDLE.
  - ch_done=0, ch_pass=0, fail_valid=0, fail_ch=0, fail_reason=0, all_done=1.
  - All channel config registers are cleared.
- Per-channel FSM: IDLE -> ARMED -> COUNT -> DONE.
- Arming:
  - cfg_we with a valid cfg_ch loads that channel's registers and moves it to ARMED from any state.
  - Arming clears the channel's ch_done, ch_pass and stored reason, and resets its timeout counter to 0.
  - If cfg_we and a hit land on the same channel in the same cycle, the configuration wins and the hit is ignored.
- ARMED, hit:
  - A hit is mem_enable_read=1 and mem_addr==addr, sampled at the rising edge.
  - On a hit: rd_err = |((mem_data_in ^ rdata) & rmask).
  - If delay==0, the result is also sampled in this same cycle and the channel moves directly to DONE.
  - Otherwise the channel loads cnt=delay and moves to COUNT.
- ARMED, timeout:
  - With no hit and timeout!=0, the timeout counter increments each cycle.
  - When the counter equals timeout, the channel moves to DONE with reason 3.
- COUNT:
  - cnt decrements every cycle. Further hits are ignored.
  - The result is sampled in the cycle where cnt==1, so it is sampled exactly delay cycles after the hit edge.
  - The channel then moves to DONE.
- Result compare:
  - res_err = |((test_data ^ exp) & emask) | (cchk & (test_carry ^ carry)).
  - reason = 1 if rd_err; else 2 if res_err; else 0.
  - ch_pass = (reason==0).
- DONE: sticky until re-armed or reset. ch_done=1.
- Channel independence: channels may watch the same address and all of them trigger on one read.
- First-fail latch:
  - Set when any channel enters DONE with reason!=0 while fail_valid=0.
  - If several channels fail in the same cycle, the lowest index wins.
  - Once set, the latch holds and later failures do not overwrite it.
  - clr clears the latch. If a failure occurs in the same cycle as clr, the failure is latched and clr loses.
- Registered outputs:
  - ch_done, ch_pass and the fail_* outputs are registered; they are visible the cycle after the DONE transition.
  - all_done is combinational from the channel states.
- Reset mid-COUNT: the channel is aborted to IDLE and no status is reported.

Test Plan:
- Arm ch0 {addr=1, delay=1, rdata=0x5x, rmask=0xF0, exp=0x0005, emask=0x000F}; run the UL LDI program (mem[1]=0x5,LDI) -> ch_done[0]=1, ch_pass[0]=1, fail_valid=0.
- Arm ch1 {addr=5, delay=1, exp=0x00AB, emask=0x00FF} and ch2 {addr=10, delay=1, exp=0x1234, emask=0xFFFF} with the LK8/LK16 program loaded -> both channels pass; all_done=1 after addr 10.
- Arm ch1 and ch3 both with a wrong exp (0x1111) so they fail in the same cycle -> fail_valid=1, fail_ch=1, fail_reason=2. A later ch0 failure does not change the latch. clr then clears it.
- Arm ch0 {addr=0x7FFF, timeout=20} -> ch_done[0]=1 and fail_reason=3 exactly 20 cycles after arming. With timeout=0 the channel stays ARMED and all_done=0.
- Arm ch0 {addr=2, delay=0, rdata=0xFF, rmask=0xFF} -> read mismatch, reason 1 even when the result also mismatches. Re-arm in the same cycle as the hit -> channel stays ARMED and no status is reported.
- Assert rst while ch2 is in COUNT with delay=3 -> all outputs return to reset values on the next edge and ch_done[2] never asserts.
